counter_sequencer: RTL and testbench

Command sequencer and two-port arbiter for the 16-bit up/down counter. Two requesters submit LOAD / COUNT-UP / COUNT-DOWN / HOLD commands over valid/ready handshakes. The block grants one command at a time with round-robin priority and drives the counter's `data_in`, `ld_cnt`, `updn_cnt` and `count_enb` for the required number of cycles. On completion it reports the resulting counter value to the issuing requester.

---
 rtl/counter_sequencer.sv | 163 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Round-robin two-port command sequencer for an up/down counter; LOAD takes 2 cycles, UP/DOWN/HOLD n takes n+1 (n=0 takes 1).
// Backpressure: reqN_ready is high only in IDLE for the granted requester; a requester holds valid until it sees ready.
module counter_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_arg,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_arg,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] cnt_data_out,
   output logic [WIDTH-1:0] data_in,
   output logic             ld_cnt,
   output logic             updn_cnt,
   output logic             count_enb,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD, S_DONE} state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_HOLD = 2'b11;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_in_q, data_in_d;
   logic             ld_cnt_q, ld_cnt_d;
   logic             updn_cnt_q, updn_cnt_d;
   logic             count_enb_q, count_enb_d;
   logic             done_q, done_d;
   logic             done_id_q, done_id_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             grant_id;
   logic             xfer;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_arg;

   always_comb begin
      grant_id   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
      req0_ready = rst_ && (state_q == S_IDLE) && req0_valid && !grant_id;
      req1_ready = rst_ && (state_q == S_IDLE) && req1_valid && grant_id;
      xfer       = req0_ready || req1_ready;
      sel_op     = grant_id ? req1_op  : req0_op;
      sel_arg    = grant_id ? req1_arg : req0_arg;
   end

   // result is registered on the counter's final edge, so it is predicted from the
   // counter's pre-edge value plus the action being applied on that same edge
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      data_in_d   = data_in_q;
      ld_cnt_d    = 1'b0;
      updn_cnt_d  = updn_cnt_q;
      count_enb_d = 1'b0;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      result_d    = result_q;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               id_d  = grant_id;
               ptr_d = ~grant_id;
               cnt_d = sel_arg;
               if (sel_op == OP_LOAD) begin
                  state_d   = S_LOAD;
                  ld_cnt_d  = 1'b1;
                  data_in_d = sel_arg;
               end else if (sel_arg == '0) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  done_id_d = grant_id;
                  result_d  = cnt_data_out;
               end else if (sel_op == OP_HOLD) begin
                  state_d = S_HOLD;
               end else begin
                  state_d     = S_RUN;
                  count_enb_d = 1'b1;
                  updn_cnt_d  = (sel_op == OP_UP);
               end
            end
         end
         S_LOAD: begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            done_id_d = id_q;
            result_d  = data_in_q;
         end
         S_RUN: begin
            cnt_d = cnt_q - WIDTH'(1);
            if (cnt_q == WIDTH'(1)) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               done_id_d = id_q;
               result_d  = updn_cnt_q ? cnt_data_out + WIDTH'(1) : cnt_data_out - WIDTH'(1);
            end else begin
               count_enb_d = 1'b1;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q - WIDTH'(1);
            if (cnt_q == WIDTH'(1)) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               done_id_d = id_q;
               result_d  = cnt_data_out;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= S_IDLE;
         ptr_q       <= 1'b0;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         data_in_q   <= '0;
         ld_cnt_q    <= 1'b0;
         updn_cnt_q  <= 1'b0;
         count_enb_q <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         data_in_q   <= data_in_d;
         ld_cnt_q    <= ld_cnt_d;
         updn_cnt_q  <= updn_cnt_d;
         count_enb_q <= count_enb_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         result_q    <= result_d;
      end
   end

   assign data_in   = data_in_q;
   assign ld_cnt    = ld_cnt_q;
   assign updn_cnt  = updn_cnt_q;
   assign count_enb = count_enb_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign result    = result_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural counter closes the loop, a scoreboard
// pushes expected completions at each handshake and checks them when done pulses.
module tb_counter_sequencer;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   logic        clk = 1'b0;
   logic        rst_ = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [1:0]  req0_op = '0, req1_op = '0;
   logic [15:0] req0_arg = '0, req1_arg = '0;
   logic        req0_ready, req1_ready;
   logic [15:0] cnt_data_out = '0;
   logic [15:0] data_in, result;
   logic        ld_cnt, updn_cnt, count_enb, done, done_id;

   counter_sequencer #(.WIDTH(16)) dut (
      .clk(clk), .rst_(rst_),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_arg(req0_arg), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_arg(req1_arg), .req1_ready(req1_ready),
      .cnt_data_out(cnt_data_out), .data_in(data_in), .ld_cnt(ld_cnt), .updn_cnt(updn_cnt),
      .count_enb(count_enb), .done(done), .done_id(done_id), .result(result)
   );

   always #5 clk = ~clk;

   // external counter, never reset by the sequencer
   always @(posedge clk) begin
      if (ld_cnt)         cnt_data_out <= data_in;
      else if (count_enb) cnt_data_out <= updn_cnt ? cnt_data_out + 16'd1 : cnt_data_out - 16'd1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        id;
      logic [15:0] res;
      int          lat;
      int          n_ld;
      int          n_en;
      int          acc;
   } exp_t;

   exp_t        sb_q[$];
   int          errs = 0, checks = 0;
   logic        ptr_m = 1'b0;
   logic [15:0] exp_cnt = '0;
   int          acc_total = 0, done_cnt = 0;
   int          n_ld = 0, n_en = 0, excl_err = 0, dir_err = 0;
   logic        cur_dir = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // monitor/scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (rst_) begin
         exp_t        e;
         logic        g;
         logic [1:0]  op;
         logic [15:0] arg;
         if (ld_cnt && count_enb) excl_err++;
         if (ld_cnt) n_ld++;
         if (count_enb) begin
            n_en++;
            if (updn_cnt !== cur_dir) dir_err++;
         end
         if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_eq("done_id", {31'd0, done_id}, {31'd0, e.id});
               check_eq("result", {16'd0, result}, {16'd0, e.res});
               check_eq("latency", cyc - e.acc, e.lat);
               check_eq("ld_cycles", n_ld, e.n_ld);
               check_eq("en_cycles", n_en, e.n_en);
               check_eq("excl_dir", excl_err + dir_err, 0);
            end
         end
         if (req0_ready || req1_ready) begin
            g = (req0_valid && req1_valid) ? ptr_m : req1_valid;
            check_eq("grant", {30'd0, req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
            op  = g ? req1_op  : req0_op;
            arg = g ? req1_arg : req0_arg;
            case (op)
               OP_LOAD: exp_cnt = arg;
               OP_UP:   exp_cnt = exp_cnt + arg;
               OP_DOWN: exp_cnt = exp_cnt - arg;
               default: exp_cnt = exp_cnt;
            endcase
            e.id   = g;
            e.res  = exp_cnt;
            e.lat  = (op == OP_LOAD) ? 2 : (arg == 16'd0 ? 1 : int'(arg) + 1);
            e.n_ld = (op == OP_LOAD) ? 1 : 0;
            e.n_en = (op == OP_UP || op == OP_DOWN) ? int'(arg) : 0;
            e.acc  = cyc;
            sb_q.push_back(e);
            ptr_m    = ~g;
            cur_dir  = (op == OP_UP);
            n_ld     = 0;
            n_en     = 0;
            excl_err = 0;
            dir_err  = 0;
            acc_total++;
         end
      end
   end

   task automatic issue(input bit who, input logic [1:0] op, input logic [15:0] arg);
      int s;
      s = acc_total;
      if (who) begin req1_op = op; req1_arg = arg; req1_valid = 1'b1; end
      else     begin req0_op = op; req0_arg = arg; req0_valid = 1'b1; end
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (acc_total > s) break;
      end
      if (acc_total == s) check_eq("accept_timeout", 32'd0, 32'd1);
      if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic run_both(input logic [15:0] a0, input logic [15:0] a1, input int n);
      int s;
      s = acc_total;
      req0_op = OP_LOAD; req0_arg = a0; req0_valid = 1'b1;
      req1_op = OP_LOAD; req1_arg = a1; req1_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (acc_total >= s + n) break;
      end
      if (acc_total < s + n) check_eq("both_timeout", acc_total - s, n);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (sb_q.size() == 0) break;
      end
      #1;
      check_eq("drain", sb_q.size(), 0);
   endtask

   task automatic rst_checks(input string pfx);
      check_eq({pfx, "_data"}, {16'd0, data_in}, 32'd0);
      check_eq({pfx, "_result"}, {16'd0, result}, 32'd0);
      check_eq({pfx, "_ctl"}, {25'd0, ld_cnt, updn_cnt, count_enb, done, done_id, req0_ready, req1_ready}, 32'd0);
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int saved;
      repeat (3) @(posedge clk);
      #1 rst_checks("reset");
      rst_ = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      issue(1'b0, OP_LOAD, 16'h1234);
      issue(1'b0, OP_LOAD, 16'h0010);
      issue(1'b1, OP_UP,   16'd5);
      issue(1'b0, OP_LOAD, 16'h0002);
      issue(1'b1, OP_DOWN, 16'd4);
      issue(1'b0, OP_UP,   16'd0);
      issue(1'b1, OP_HOLD, 16'd3);
      issue(1'b0, OP_DOWN, 16'd0);
      issue(1'b0, OP_HOLD, 16'd0);
      issue(1'b1, OP_UP,   16'd300);
      drain();

      run_both(16'd1, 16'd2, 4);
      drain();

      issue(1'b0, OP_LOAD, 16'h00A5);
      issue(1'b1, OP_UP, 16'd10);
      @(posedge clk);
      @(posedge clk);
      #2 rst_ = 1'b0;
      #1 rst_checks("abort");
      sb_q.delete();
      ptr_m = 1'b0;
      saved = done_cnt;
      repeat (2) @(posedge clk);
      #1 rst_ = 1'b1;
      repeat (15) @(posedge clk);
      #1 check_eq("no_done_after_abort", done_cnt, saved);

      req0_op = OP_LOAD; req0_arg = 16'd7; req0_valid = 1'b1;
      req1_op = OP_LOAD; req1_arg = 16'd9; req1_valid = 1'b1;
      @(negedge clk);
      check_eq("post_rst_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
      run_both(16'd7, 16'd9, 2);
      drain();

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
